// File: rtl/psram_arbiter.sv
// -----------------------------------------------------------------------------
// psram_arbiter
//
// Purpose:
//   Shares the single-port PSRAM byte controller between the game loader's
//   write stream and the Atari bus read path. Arbitrates between the two
//   requesters, walks each transaction through the controller's
//   pulse / busy / valid handshake, and keeps a one-entry read cache so that
//   repeated CPU reads of the same byte are answered without touching PSRAM.
//
// Ports:
//   clk, reset_n        27 MHz clock, synchronous active-low reset
//   cpu_read_req        CPU read request (level, held until cpu_ack)
//   cpu_addr[21:0]      CPU read byte address
//   cpu_ack             one-cycle pulse, cpu_data valid in this cycle
//   cpu_data[7:0]       read data, holds between acks
//   ld_write_req        loader write request (level, held until ld_ack)
//   ld_addr[21:0]       loader write address
//   ld_data[7:0]        loader write data
//   ld_ack              one-cycle pulse, write complete
//   xfer_err            one-cycle pulse alongside an ack that ended by timeout
//   timeout_seen        sticky timeout flag, cleared only by reset
//   cache_flush         pulse, invalidates the read cache
//   mem_read_req        one-cycle read request pulse to the controller
//   mem_write_req       one-cycle write request pulse to the controller
//   mem_addr[21:0]      registered transaction address
//   mem_wdata[7:0]      registered write data
//   mem_rdata[7:0]      controller read data
//   mem_valid           controller read-data strobe
//   mem_busy            controller busy
// -----------------------------------------------------------------------------
module psram_arbiter #(
    parameter int STARVE_LIMIT   = 8,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        cpu_read_req,
    input  logic [21:0] cpu_addr,
    output logic        cpu_ack,
    output logic [7:0]  cpu_data,
    input  logic        ld_write_req,
    input  logic [21:0] ld_addr,
    input  logic [7:0]  ld_data,
    output logic        ld_ack,
    output logic        xfer_err,
    output logic        timeout_seen,
    input  logic        cache_flush,
    output logic        mem_read_req,
    output logic        mem_write_req,
    output logic [21:0] mem_addr,
    output logic [7:0]  mem_wdata,
    input  logic [7:0]  mem_rdata,
    input  logic        mem_valid,
    input  logic        mem_busy
);

    localparam int SW = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;
    localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);
    localparam logic [TW-1:0] TMO_LAST   = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [7:0]    ERR_DATA   = 8'hEA;

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        WAIT_START = 2'd1,
        WAIT_DONE  = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic        is_write_q, is_write_d;
    logic [TW-1:0] tmo_cnt_q, tmo_cnt_d;
    logic [SW-1:0] starve_cnt_q, starve_cnt_d;
    logic        cache_valid_q, cache_valid_d;
    logic [21:0] cache_addr_q, cache_addr_d;
    logic [7:0]  cache_data_q, cache_data_d;
    logic [7:0]  cpu_data_q, cpu_data_d;
    logic        cpu_ack_q, cpu_ack_d;
    logic        ld_ack_q, ld_ack_d;
    logic        xfer_err_q, xfer_err_d;
    logic        timeout_seen_q, timeout_seen_d;
    logic        mem_read_req_q, mem_read_req_d;
    logic        mem_write_req_q, mem_write_req_d;
    logic [21:0] mem_addr_q, mem_addr_d;
    logic [7:0]  mem_wdata_q, mem_wdata_d;

    logic        cpu_elig;
    logic        ld_elig;
    logic        grant_cpu;
    logic        grant_ld;
    logic        xfer_done;

    // A requester acked in this cycle is still holding its request level;
    // ignoring it here stops it from being served twice.
    assign cpu_elig = cpu_read_req && !cpu_ack_q;
    assign ld_elig  = ld_write_req && !ld_ack_q;

    always_comb begin
        state_d         = state_q;
        is_write_d      = is_write_q;
        tmo_cnt_d       = tmo_cnt_q;
        starve_cnt_d    = starve_cnt_q;
        cache_valid_d   = cache_valid_q;
        cache_addr_d    = cache_addr_q;
        cache_data_d    = cache_data_q;
        cpu_data_d      = cpu_data_q;
        cpu_ack_d       = 1'b0;
        ld_ack_d        = 1'b0;
        xfer_err_d      = 1'b0;
        timeout_seen_d  = timeout_seen_q;
        mem_read_req_d  = 1'b0;
        mem_write_req_d = 1'b0;
        mem_addr_d      = mem_addr_q;
        mem_wdata_d     = mem_wdata_q;
        grant_cpu       = 1'b0;
        grant_ld        = 1'b0;
        xfer_done       = 1'b0;

        case (state_q)
            IDLE: begin
                // A flush arriving with the request suppresses the hit.
                if (cpu_elig && cache_valid_q && !cache_flush &&
                    (cpu_addr == cache_addr_q)) begin
                    cpu_ack_d  = 1'b1;
                    cpu_data_d = cache_data_q;
                end else if (!mem_busy) begin
                    if (ld_elig && (!cpu_elig || (starve_cnt_q == STARVE_MAX))) begin
                        grant_ld = 1'b1;
                    end else if (cpu_elig) begin
                        grant_cpu = 1'b1;
                    end
                end

                if (grant_ld) begin
                    starve_cnt_d    = '0;
                    mem_addr_d      = ld_addr;
                    mem_wdata_d     = ld_data;
                    mem_write_req_d = 1'b1;
                    is_write_d      = 1'b1;
                    tmo_cnt_d       = '0;
                    state_d         = WAIT_START;
                end

                if (grant_cpu) begin
                    if (ld_write_req) begin
                        starve_cnt_d = (starve_cnt_q == STARVE_MAX) ? STARVE_MAX
                                                                    : starve_cnt_q + 1'b1;
                    end else begin
                        starve_cnt_d = '0;
                    end
                    mem_addr_d     = cpu_addr;
                    mem_read_req_d = 1'b1;
                    is_write_d     = 1'b0;
                    tmo_cnt_d      = '0;
                    state_d        = WAIT_START;
                end
            end

            WAIT_START, WAIT_DONE: begin
                // Reads may complete straight from WAIT_START; writes only
                // finish once busy has been seen and then drops.
                if (is_write_q) begin
                    xfer_done = (state_q == WAIT_DONE) && !mem_busy;
                end else begin
                    xfer_done = mem_valid;
                end

                if (xfer_done) begin
                    state_d = IDLE;
                    if (is_write_q) begin
                        ld_ack_d = 1'b1;
                        // Keep the cached byte coherent with the write.
                        if (cache_valid_q && (mem_addr_q == cache_addr_q)) begin
                            cache_data_d = mem_wdata_q;
                        end
                    end else begin
                        cpu_ack_d     = 1'b1;
                        cpu_data_d    = mem_rdata;
                        cache_data_d  = mem_rdata;
                        cache_addr_d  = mem_addr_q;
                        cache_valid_d = 1'b1;
                    end
                end else if (tmo_cnt_q == TMO_LAST) begin
                    state_d        = IDLE;
                    xfer_err_d     = 1'b1;
                    timeout_seen_d = 1'b1;
                    if (is_write_q) begin
                        ld_ack_d = 1'b1;
                    end else begin
                        cpu_ack_d  = 1'b1;
                        cpu_data_d = ERR_DATA;
                    end
                end else begin
                    tmo_cnt_d = tmo_cnt_q + 1'b1;
                    if ((state_q == WAIT_START) && mem_busy) begin
                        state_d = WAIT_DONE;
                    end
                end
            end

            default: state_d = IDLE;
        endcase

        // Flush has the last word, including over a read fill this cycle.
        if (cache_flush) begin
            cache_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q         <= IDLE;
            is_write_q      <= 1'b0;
            tmo_cnt_q       <= '0;
            starve_cnt_q    <= '0;
            cache_valid_q   <= 1'b0;
            cpu_data_q      <= 8'h00;
            cpu_ack_q       <= 1'b0;
            ld_ack_q        <= 1'b0;
            xfer_err_q      <= 1'b0;
            timeout_seen_q  <= 1'b0;
            mem_read_req_q  <= 1'b0;
            mem_write_req_q <= 1'b0;
            mem_addr_q      <= 22'd0;
            mem_wdata_q     <= 8'h00;
        end else begin
            state_q         <= state_d;
            is_write_q      <= is_write_d;
            tmo_cnt_q       <= tmo_cnt_d;
            starve_cnt_q    <= starve_cnt_d;
            cache_valid_q   <= cache_valid_d;
            cpu_data_q      <= cpu_data_d;
            cpu_ack_q       <= cpu_ack_d;
            ld_ack_q        <= ld_ack_d;
            xfer_err_q      <= xfer_err_d;
            timeout_seen_q  <= timeout_seen_d;
            mem_read_req_q  <= mem_read_req_d;
            mem_write_req_q <= mem_write_req_d;
            mem_addr_q      <= mem_addr_d;
            mem_wdata_q     <= mem_wdata_d;
        end
    end

    // Cache contents are qualified by cache_valid_q, so they need no reset.
    always_ff @(posedge clk) begin
        cache_addr_q <= cache_addr_d;
        cache_data_q <= cache_data_d;
    end

    assign cpu_ack       = cpu_ack_q;
    assign cpu_data      = cpu_data_q;
    assign ld_ack        = ld_ack_q;
    assign xfer_err      = xfer_err_q;
    assign timeout_seen  = timeout_seen_q;
    assign mem_read_req  = mem_read_req_q;
    assign mem_write_req = mem_write_req_q;
    assign mem_addr      = mem_addr_q;
    assign mem_wdata     = mem_wdata_q;

endmodule

// File: tb/tb_psram_arbiter.sv
// -----------------------------------------------------------------------------
// tb_psram_arbiter
//
// Drives the arbiter with directed and randomized CPU reads, loader writes
// and cache flushes against a behavioural PSRAM device. Expected read data
// comes from a reference byte array plus an abstract model of the one-entry
// cache; expectations are queued at issue and checked by a separate monitor.
// -----------------------------------------------------------------------------
module tb_psram_arbiter;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        cpu_read_req;
    logic [21:0] cpu_addr;
    logic        cpu_ack;
    logic [7:0]  cpu_data;
    logic        ld_write_req;
    logic [21:0] ld_addr;
    logic [7:0]  ld_data;
    logic        ld_ack;
    logic        xfer_err;
    logic        timeout_seen;
    logic        cache_flush;
    logic        mem_read_req;
    logic        mem_write_req;
    logic [21:0] mem_addr;
    logic [7:0]  mem_wdata;
    logic [7:0]  mem_rdata;
    logic        mem_valid;
    logic        mem_busy;

    always #5 clk = ~clk;

    psram_arbiter #(.STARVE_LIMIT(8), .TIMEOUT_CYCLES(64)) dut (
        .clk(clk), .reset_n(reset_n),
        .cpu_read_req(cpu_read_req), .cpu_addr(cpu_addr),
        .cpu_ack(cpu_ack), .cpu_data(cpu_data),
        .ld_write_req(ld_write_req), .ld_addr(ld_addr), .ld_data(ld_data),
        .ld_ack(ld_ack), .xfer_err(xfer_err), .timeout_seen(timeout_seen),
        .cache_flush(cache_flush),
        .mem_read_req(mem_read_req), .mem_write_req(mem_write_req),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_valid(mem_valid), .mem_busy(mem_busy)
    );

    typedef struct {
        logic [7:0] data;
        logic       err;
        logic       hit;
    } rd_exp_t;

    int n_tests = 0;
    int n_fail  = 0;

    rd_exp_t rd_q[$];
    logic    ld_q[$];
    logic    req_log[$];

    // Reference contents and abstract cache state
    logic [7:0] ref_mem   [logic [21:0]];
    logic [7:0] psram_arr [logic [21:0]];
    logic       m_cache_v = 1'b0;
    logic [21:0] m_cache_a = 22'd0;

    // Behavioural device knobs
    int   dev_lat_busy = 2;
    int   dev_lat_done = 8;
    logic dev_dead = 1'b0;
    logic dev_idle = 1'b1;

    function automatic logic [7:0] init_val(input logic [21:0] a);
        return a[7:0] ^ 8'hA5;
    endfunction

    function automatic logic [7:0] ref_rd(input logic [21:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : init_val(a);
    endfunction

    function automatic void check(input string name, input logic [31:0] act,
                                  input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // ---------------- behavioural PSRAM controller ----------------
    initial begin : psram_model
        logic [21:0] a;
        logic [7:0]  d;
        logic        rd;
        mem_busy  = 1'b0;
        mem_valid = 1'b0;
        mem_rdata = 8'h00;
        forever begin
            tick();
            if ((mem_read_req || mem_write_req) && !dev_dead && reset_n) begin
                rd = mem_read_req;
                a  = mem_addr;
                d  = mem_wdata;
                dev_idle = 1'b0;
                repeat (dev_lat_busy) tick();
                mem_busy = 1'b1;
                repeat (dev_lat_done) tick();
                if (rd) begin
                    mem_valid = 1'b1;
                    mem_rdata = psram_arr.exists(a) ? psram_arr[a] : init_val(a);
                    tick();
                    mem_valid = 1'b0;
                    tick();
                    mem_busy = 1'b0;
                end else begin
                    psram_arr[a] = d;
                    mem_busy = 1'b0;
                end
                dev_idle = 1'b1;
            end
        end
    end

    // ---------------- monitor / scoreboard ----------------
    initial begin : monitor
        int      rd_reqs;
        int      wr_reqs;
        rd_exp_t e;
        logic    we;
        rd_reqs = 0;
        wr_reqs = 0;
        forever begin
            tick();
            if (!reset_n) begin
                rd_reqs = 0;
                wr_reqs = 0;
            end else begin
                if (mem_read_req) begin rd_reqs++; req_log.push_back(1'b0); end
                if (mem_write_req) begin wr_reqs++; req_log.push_back(1'b1); end
                if (cpu_ack) begin
                    if (rd_q.size() == 0) begin
                        n_tests++; n_fail++;
                        $display("FAIL cpu_ack_unexpected: ack with data 0x%0h, no read outstanding", cpu_data);
                    end else begin
                        e = rd_q.pop_front();
                        check("rd_data", cpu_data, e.data);
                        check("rd_err", xfer_err, e.err);
                        check("rd_mem_reqs", rd_reqs, e.hit ? 0 : 1);
                    end
                    rd_reqs = 0;
                end
                if (ld_ack) begin
                    if (ld_q.size() == 0) begin
                        n_tests++; n_fail++;
                        $display("FAIL ld_ack_unexpected: ack with no write outstanding");
                    end else begin
                        we = ld_q.pop_front();
                        check("wr_err", xfer_err, we);
                        check("wr_mem_reqs", wr_reqs, 1);
                    end
                    wr_reqs = 0;
                end
                if (xfer_err && !cpu_ack && !ld_ack) begin
                    n_tests++; n_fail++;
                    $display("FAIL xfer_err_alone: xfer_err high without an ack");
                end
            end
        end
    end

    // ---------------- stimulus tasks ----------------
    task automatic cpu_read(input logic [21:0] a, input bit with_flush,
                            output int lat, output int req_lat, output int vld_lat);
        rd_exp_t e;
        int req_at;
        int vld_at;
        if (with_flush) m_cache_v = 1'b0;
        e.hit  = m_cache_v && (m_cache_a == a);
        e.err  = dev_dead && !e.hit;
        e.data = e.err ? 8'hEA : ref_rd(a);
        rd_q.push_back(e);
        cpu_addr     = a;
        cpu_read_req = 1'b1;
        cache_flush  = with_flush;
        lat = 0; req_at = -1; vld_at = -1;
        forever begin
            tick();
            lat++;
            cache_flush = 1'b0;
            if (mem_read_req) begin
                req_at = lat;
                cpu_addr = a ^ 22'h3FFFFF;   // must not disturb the latched address
            end
            if (mem_valid) vld_at = lat;
            if (cpu_ack) break;
            if (lat > 400) begin
                n_tests++; n_fail++;
                $display("FAIL cpu_read_wait: no cpu_ack for addr 0x%0h after %0d cycles", a, lat);
                break;
            end
        end
        cpu_read_req = 1'b0;
        req_lat = (req_at >= 0) ? lat - req_at : -1;
        vld_lat = (vld_at >= 0) ? lat - vld_at : -1;
        if (!e.err) begin
            m_cache_v = 1'b1;
            m_cache_a = a;
        end
    endtask

    task automatic ld_write(input logic [21:0] a, input logic [7:0] d);
        int n;
        ld_q.push_back(1'b0);
        ref_mem[a]   = d;
        ld_addr      = a;
        ld_data      = d;
        ld_write_req = 1'b1;
        n = 0;
        forever begin
            tick();
            n++;
            if (mem_write_req) begin
                ld_addr = a ^ 22'h2AAAAA;
                ld_data = ~d;
            end
            if (ld_ack) break;
            if (n > 400) begin
                n_tests++; n_fail++;
                $display("FAIL ld_write_wait: no ld_ack for addr 0x%0h after %0d cycles", a, n);
                break;
            end
        end
        ld_write_req = 1'b0;
    endtask

    task automatic do_flush();
        cache_flush = 1'b1;
        tick();
        cache_flush = 1'b0;
        m_cache_v   = 1'b0;
    endtask

    task automatic wait_dev_idle();
        int n;
        n = 0;
        tick();
        while (!(dev_idle && !mem_busy)) begin
            tick();
            n++;
            if (n > 200) begin
                n_tests++; n_fail++;
                $display("FAIL dev_idle_wait: device still busy after %0d cycles", n);
                break;
            end
        end
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_cpu_ack"},      cpu_ack,       0);
        check({tag, "_ld_ack"},       ld_ack,        0);
        check({tag, "_xfer_err"},     xfer_err,      0);
        check({tag, "_timeout_seen"}, timeout_seen,  0);
        check({tag, "_cpu_data"},     cpu_data,      0);
        check({tag, "_mem_addr"},     mem_addr,      0);
        check({tag, "_mem_wdata"},    mem_wdata,     0);
        check({tag, "_mem_rd_req"},   mem_read_req,  0);
        check({tag, "_mem_wr_req"},   mem_write_req, 0);
    endtask

    initial begin : watchdog
        #600000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    // ---------------- main sequence ----------------
    initial begin : main
        int l1, r1, v1, l2, r2, v2;
        int op;
        logic [21:0] ra, wa;
        logic [7:0]  wd;
        logic        ack_seen;
        int          n;

        reset_n = 1'b0; cpu_read_req = 1'b0; cpu_addr = '0;
        ld_write_req = 1'b0; ld_addr = '0; ld_data = '0; cache_flush = 1'b0;
        psram_arr[22'h000123] = 8'h5A; ref_mem[22'h000123] = 8'h5A;
        psram_arr[22'h000040] = 8'h11; ref_mem[22'h000040] = 8'h11;
        repeat (3) tick();
        check_reset_vals("rst");
        reset_n = 1'b1;
        tick();

        // Read miss then hit
        dev_lat_busy = 2; dev_lat_done = 8;
        cpu_read(22'h000123, 1'b0, l1, r1, v1);
        check("miss_data", cpu_data, 8'h5A);
        check("miss_ack_after_valid", v1, 1);
        wait_dev_idle();
        cpu_read(22'h000123, 1'b0, l1, r1, v1);
        check("hit_latency", l1, 1);
        check("hit_no_mem_req", r1, -1);
        repeat (4) tick();
        check("cpu_data_hold", cpu_data, 8'h5A);

        // Simultaneous requests: CPU first, then loader
        req_log.delete();
        fork
            cpu_read(22'h000600, 1'b0, l1, r1, v1);
            ld_write(22'h000601, 8'h3C);
        join
        wait_dev_idle();
        check("simul_req_count", req_log.size(), 2);
        if (req_log.size() >= 2) begin
            check("simul_first_is_read", req_log[0], 1'b0);
            check("simul_second_is_write", req_log[1], 1'b1);
        end

        // Starvation guard: loader held while CPU reads 12 distinct bytes
        req_log.delete();
        fork
            for (int i = 0; i < 12; i++) cpu_read(22'(22'h001000 + i), 1'b0, l1, r1, v1);
            ld_write(22'h002000, 8'h77);
        join
        wait_dev_idle();
        check("starve_req_count", req_log.size(), 13);
        for (int i = 0; i < 13; i++) begin
            if (i < req_log.size()) check($sformatf("starve_order_%0d", i), req_log[i], (i == 8) ? 1 : 0);
        end

        // Write coherency and flush
        cpu_read(22'h000040, 1'b0, l1, r1, v1);
        check("coh_first_data", cpu_data, 8'h11);
        wait_dev_idle();
        ld_write(22'h000040, 8'h22);
        wait_dev_idle();
        cpu_read(22'h000040, 1'b0, l1, r1, v1);
        check("coh_hit_latency", l1, 1);
        check("coh_hit_data", cpu_data, 8'h22);
        wait_dev_idle();
        do_flush();
        cpu_read(22'h000040, 1'b0, l1, r1, v1);
        check("coh_flush_forces_miss", r1 >= 0, 1);
        wait_dev_idle();
        cpu_read(22'h000040, 1'b1, l1, r1, v1);
        check("flush_with_hit_is_miss", r1 >= 0, 1);
        wait_dev_idle();

        // Timeout, then normal service
        dev_dead = 1'b1;
        cpu_read(22'h000300, 1'b0, l1, r1, v1);
        check("tmo_cycles", r1, 64);
        check("tmo_data", cpu_data, 8'hEA);
        check("tmo_seen", timeout_seen, 1);
        dev_dead = 1'b0;
        tick();
        cpu_read(22'h000301, 1'b0, l1, r1, v1);
        check("tmo_recover_data", cpu_data, init_val(22'h000301));
        check("tmo_seen_sticky", timeout_seen, 1);
        wait_dev_idle();

        // Reset while waiting for completion
        dev_lat_done = 30;
        cpu_addr = 22'h000500;
        cpu_read_req = 1'b1;
        n = 0;
        while (!mem_busy && n < 50) begin tick(); n++; end
        tick(); tick();
        reset_n = 1'b0;
        cpu_read_req = 1'b0;
        tick();
        check_reset_vals("midrst");
        ack_seen = 1'b0;
        n = 0;
        while (!dev_idle && n < 100) begin
            tick(); n++;
            if (cpu_ack || ld_ack) ack_seen = 1'b1;
        end
        check("midrst_no_ack", ack_seen, 0);
        reset_n = 1'b1;
        m_cache_v = 1'b0;
        dev_lat_done = 4;
        wait_dev_idle();
        cpu_read(22'h000040, 1'b0, l1, r1, v1);
        check("midrst_cache_invalid", r1 >= 0, 1);
        wait_dev_idle();

        // Randomized mix
        for (int it = 0; it < 40; it++) begin
            wait_dev_idle();
            dev_lat_busy = $urandom_range(1, 3);
            dev_lat_done = $urandom_range(1, 6);
            op = $urandom_range(0, 3);
            ra = 22'(22'h000040 + $urandom_range(0, 7));
            wa = 22'(22'h000040 + $urandom_range(0, 7));
            wd = 8'($urandom);
            case (op)
                0: cpu_read(ra, 1'b0, l1, r1, v1);
                1: ld_write(wa, wd);
                2: begin
                    wa = ra ^ 22'h000001;
                    fork
                        cpu_read(ra, 1'b0, l1, r1, v1);
                        ld_write(wa, wd);
                    join
                end
                default: begin
                    if ($urandom_range(0, 1) == 1) do_flush();
                    else cpu_read(ra, 1'b1, l2, r2, v2);
                end
            endcase
        end

        wait_dev_idle();
        repeat (3) tick();
        check("rd_queue_drained", rd_q.size(), 0);
        check("ld_queue_drained", ld_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
